// File: rtl/sel_wss_mod.sv
// Picks the SMO working pair: scans the label/alpha/gradient RAMs once, tracking argmax -y*g over I_up
// and argmin -y*g over I_low. Finish comes n_vector+2 cycles after start (1 when n_vector is 0). start is ignored while busy.
module sel_wss_mod #(
  parameter int AW = 11,
  parameter int DW = 64
) (
  input  logic          clk,
  input  logic          rst_,
  input  logic          start,
  input  logic [AW-1:0] n_vector,
  input  logic [DW-1:0] c_bound,
  input  logic [DW-1:0] eps,
  output logic [AW-1:0] ram_rd_addr,
  input  logic          ram_label_q,
  input  logic [DW-1:0] ram_a_q,
  input  logic [DW-1:0] ram_a_grad_q,
  output logic          busy,
  output logic [AW-1:0] idx_i,
  output logic [AW-1:0] idx_j,
  output logic          valid_i,
  output logic          valid_j,
  output logic [DW:0]   gap,
  output logic          converged,
  output logic          finish
);

  typedef enum logic [1:0] {IDLE, SCAN, DRAIN, DONE} state_t;

  localparam logic [DW-1:0] SMAX = {1'b0, {(DW-1){1'b1}}};
  localparam logic [DW-1:0] SMIN = {1'b1, {(DW-1){1'b0}}};

  state_t        state_q, state_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [AW-1:0] n_q, n_d;
  logic [DW-1:0] c_q, c_d;
  logic [DW-1:0] eps_q, eps_d;
  logic          pend_vld_q, pend_vld_d;
  logic [AW-1:0] pend_idx_q, pend_idx_d;
  logic [DW-1:0] m_max_q, m_max_d;
  logic [DW-1:0] m_min_q, m_min_d;
  logic [AW-1:0] idx_i_q, idx_i_d;
  logic [AW-1:0] idx_j_q, idx_j_d;
  logic          valid_i_q, valid_i_d;
  logic          valid_j_q, valid_j_d;
  logic [DW:0]   gap_q, gap_d;
  logic          conv_q, conv_d;
  logic          busy_q, busy_d;
  logic          finish_q, finish_d;

  logic [DW-1:0]        neg_g, v;
  logic                 a_pos, a_ltc, in_up, in_low;
  logic signed [DW:0]   gap_calc;

  // Datum classification for the word currently on the RAM outputs.
  always_comb begin
    neg_g  = (ram_a_grad_q == SMIN) ? SMAX : -ram_a_grad_q;
    v      = ram_label_q ? neg_g : ram_a_grad_q;
    a_pos  = $signed(ram_a_q) > 0;
    a_ltc  = $signed(ram_a_q) < $signed(c_q);
    in_up  = ram_label_q ? a_ltc : a_pos;
    in_low = ram_label_q ? a_pos : a_ltc;
  end

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    n_d        = n_q;
    c_d        = c_q;
    eps_d      = eps_q;
    pend_vld_d = 1'b0;
    pend_idx_d = pend_idx_q;
    m_max_d    = m_max_q;
    m_min_d    = m_min_q;
    idx_i_d    = idx_i_q;
    idx_j_d    = idx_j_q;
    valid_i_d  = valid_i_q;
    valid_j_d  = valid_j_q;
    gap_d      = gap_q;
    conv_d     = conv_q;
    busy_d     = busy_q;
    finish_d   = 1'b0;

    // Strict compares keep the lowest index on ties.
    if (pend_vld_q) begin
      if (in_up && (!valid_i_q || $signed(v) > $signed(m_max_q))) begin
        m_max_d   = v;
        idx_i_d   = pend_idx_q;
        valid_i_d = 1'b1;
      end
      if (in_low && (!valid_j_q || $signed(v) < $signed(m_min_q))) begin
        m_min_d   = v;
        idx_j_d   = pend_idx_q;
        valid_j_d = 1'b1;
      end
    end

    gap_calc = $signed({m_max_d[DW-1], m_max_d}) - $signed({m_min_d[DW-1], m_min_d});

    case (state_q)
      IDLE: begin
        busy_d = 1'b0;
        if (start) begin
          n_d       = n_vector;
          c_d       = c_bound;
          eps_d     = eps;
          valid_i_d = 1'b0;
          valid_j_d = 1'b0;
          idx_i_d   = '0;
          idx_j_d   = '0;
          busy_d    = 1'b1;
          if (n_vector == '0) begin
            state_d  = DONE;
            gap_d    = '0;
            conv_d   = 1'b1;
            finish_d = 1'b1;
          end else begin
            state_d = SCAN;
            addr_d  = '0;
          end
        end
      end
      SCAN: begin
        pend_vld_d = 1'b1;
        pend_idx_d = addr_q;
        if (addr_q == n_q - AW'(1)) state_d = DRAIN;
        else                        addr_d  = addr_q + AW'(1);
      end
      DRAIN: begin
        state_d  = DONE;
        finish_d = 1'b1;
        if (valid_i_d && valid_j_d) begin
          gap_d  = gap_calc;
          conv_d = gap_calc <= $signed({eps_q[DW-1], eps_q});
        end else begin
          gap_d  = '0;
          conv_d = 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst_) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      n_q        <= '0;
      c_q        <= '0;
      eps_q      <= '0;
      pend_vld_q <= 1'b0;
      pend_idx_q <= '0;
      m_max_q    <= '0;
      m_min_q    <= '0;
      idx_i_q    <= '0;
      idx_j_q    <= '0;
      valid_i_q  <= 1'b0;
      valid_j_q  <= 1'b0;
      gap_q      <= '0;
      conv_q     <= 1'b0;
      busy_q     <= 1'b0;
      finish_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      n_q        <= n_d;
      c_q        <= c_d;
      eps_q      <= eps_d;
      pend_vld_q <= pend_vld_d;
      pend_idx_q <= pend_idx_d;
      m_max_q    <= m_max_d;
      m_min_q    <= m_min_d;
      idx_i_q    <= idx_i_d;
      idx_j_q    <= idx_j_d;
      valid_i_q  <= valid_i_d;
      valid_j_q  <= valid_j_d;
      gap_q      <= gap_d;
      conv_q     <= conv_d;
      busy_q     <= busy_d;
      finish_q   <= finish_d;
    end
  end

  assign ram_rd_addr = addr_q;
  assign busy        = busy_q;
  assign idx_i       = idx_i_q;
  assign idx_j       = idx_j_q;
  assign valid_i     = valid_i_q;
  assign valid_j     = valid_j_q;
  assign gap         = gap_q;
  assign converged   = conv_q;
  assign finish      = finish_q;

endmodule

// File: tb/tb_sel_wss_mod.sv
// Scoreboard bench for sel_wss_mod: expected results are queued at start and checked on each finish pulse.
module tb_sel_wss_mod;
  localparam int AW = 11;
  localparam int DW = 64;

  logic          clk = 1'b0;
  logic          rst_;
  logic          start;
  logic [AW-1:0] n_vector;
  logic [DW-1:0] c_bound;
  logic [DW-1:0] eps;
  logic [AW-1:0] ram_rd_addr;
  logic          ram_label_q;
  logic [DW-1:0] ram_a_q;
  logic [DW-1:0] ram_a_grad_q;
  logic          busy;
  logic [AW-1:0] idx_i;
  logic [AW-1:0] idx_j;
  logic          valid_i;
  logic          valid_j;
  logic [DW:0]   gap;
  logic          converged;
  logic          finish;

  sel_wss_mod #(.AW(AW), .DW(DW)) dut (
    .clk(clk), .rst_(rst_), .start(start), .n_vector(n_vector), .c_bound(c_bound), .eps(eps),
    .ram_rd_addr(ram_rd_addr), .ram_label_q(ram_label_q), .ram_a_q(ram_a_q),
    .ram_a_grad_q(ram_a_grad_q), .busy(busy), .idx_i(idx_i), .idx_j(idx_j),
    .valid_i(valid_i), .valid_j(valid_j), .gap(gap), .converged(converged), .finish(finish)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  bit          lab_m [16];
  logic [63:0] a_m   [16];
  logic [63:0] g_m   [16];

  // One-cycle-latency RAM model
  always @(posedge clk) begin
    ram_label_q  <= lab_m[ram_rd_addr[3:0]];
    ram_a_q      <= a_m[ram_rd_addr[3:0]];
    ram_a_grad_q <= g_m[ram_rd_addr[3:0]];
  end

  typedef struct {
    int          lat;
    logic [10:0] ii;
    logic [10:0] jj;
    logic        vi;
    logic        vj;
    logic [64:0] gap;
    logic        conv;
    int          scyc;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec   = 0;
  int   n_mis   = 0;
  int   fin_cnt = 0;

  task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] expv);
    n_vec++;
    if (obs !== expv) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, expv);
    end
  endtask

  function automatic exp_t ref_scan(input int n, input longint c, input longint e);
    exp_t r;
    longint mx, mn, v, g, a;
    longint minv, maxv;
    bit up, lo;
    logic signed [64:0] ex, en, gp;
    minv = 64'h8000_0000_0000_0000;
    maxv = 64'h7fff_ffff_ffff_ffff;
    r.ii = '0; r.jj = '0; r.vi = 1'b0; r.vj = 1'b0; r.gap = '0; r.conv = 1'b1; r.scyc = 0;
    mx = 0; mn = 0;
    for (int k = 0; k < n; k++) begin
      g  = g_m[k];
      a  = a_m[k];
      v  = lab_m[k] ? ((g == minv) ? maxv : -g) : g;
      up = lab_m[k] ? (a < c) : (a > 0);
      lo = lab_m[k] ? (a > 0) : (a < c);
      if (up && (!r.vi || v > mx)) begin mx = v; r.ii = 11'(k); r.vi = 1'b1; end
      if (lo && (!r.vj || v < mn)) begin mn = v; r.jj = 11'(k); r.vj = 1'b1; end
    end
    if (r.vi && r.vj) begin
      ex = mx; en = mn; gp = ex - en;
      r.gap  = gp;
      r.conv = (gp <= e);
    end
    r.lat = (n == 0) ? 1 : n + 2;
    return r;
  endfunction

  always @(negedge clk) begin
    if (finish) begin
      exp_t e;
      fin_cnt++;
      if (exp_q.size() == 0) begin
        chk("spurious_finish", 96'(1), 96'(0));
      end else begin
        e = exp_q.pop_front();
        chk("latency",   96'(cyc - e.scyc + 1), 96'(e.lat));
        chk("busy_fin",  96'(busy),      96'(1));
        chk("idx_i",     96'(idx_i),     96'(e.ii));
        chk("idx_j",     96'(idx_j),     96'(e.jj));
        chk("valid_i",   96'(valid_i),   96'(e.vi));
        chk("valid_j",   96'(valid_j),   96'(e.vj));
        chk("gap",       96'(gap),       96'(e.gap));
        chk("converged", 96'(converged), 96'(e.conv));
      end
    end
  end

  task automatic load(input int k, input bit y, input longint a, input longint g);
    lab_m[k] = y;
    a_m[k]   = a;
    g_m[k]   = g;
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_busy"},   96'(busy),        96'(0));
    chk({tag, "_finish"}, 96'(finish),      96'(0));
    chk({tag, "_vi"},     96'(valid_i),     96'(0));
    chk({tag, "_vj"},     96'(valid_j),     96'(0));
    chk({tag, "_conv"},   96'(converged),   96'(0));
    chk({tag, "_idx_i"},  96'(idx_i),       96'(0));
    chk({tag, "_idx_j"},  96'(idx_j),       96'(0));
    chk({tag, "_gap"},    96'(gap),         96'(0));
    chk({tag, "_addr"},   96'(ram_rd_addr), 96'(0));
  endtask

  // Starts a scan (accepted once busy rises) and returns at the finish negedge.
  task automatic run_scan(input int n, input longint c, input longint e, input bit poke);
    exp_t r;
    int   k;
    int   f0;
    f0       = fin_cnt;
    start    = 1'b1;
    n_vector = AW'(n);
    c_bound  = c;
    eps      = e;
    for (k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      if (busy) break;
    end
    start = 1'b0;
    if (k == 10) begin
      chk("start_accept", 96'(0), 96'(1));
      return;
    end
    r      = ref_scan(n, c, e);
    r.scyc = cyc;
    exp_q.push_back(r);
    if (poke) begin
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
    end
    if (!(poke && n == 0)) begin
      for (k = 0; k < n + 20; k++) begin
        @(negedge clk);
        if (finish) break;
      end
      if (!finish) chk("finish_timeout", 96'(0), 96'(1));
    end
    if (poke) begin
      repeat (n + 6) @(negedge clk);
      chk("finish_count", 96'(fin_cnt - f0), 96'(1));
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    for (int k = 0; k < 16; k++) load(k, 1'b0, 0, 0);
    rst_ = 1'b1; start = 1'b0; n_vector = '0; c_bound = '0; eps = '0;
    repeat (3) @(posedge clk);
    #1;
    check_zero("rst");
    rst_ = 1'b0;
    @(negedge clk);

    // Reset mid-scan: n=8, reset asserted in cycle 4 of the scan
    for (int k = 0; k < 8; k++) load(k, 1'(k % 2), 1, longint'(k) - 4);
    start = 1'b1; n_vector = AW'(8); c_bound = 10; eps = 0;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_ = 1'b1;
    @(posedge clk); #1;
    rst_ = 1'b0;
    check_zero("midrst");
    begin
      int f0;
      f0 = fin_cnt;
      repeat (15) @(negedge clk);
      chk("midrst_nofinish", 96'(fin_cnt - f0), 96'(0));
    end

    // Basic pair selection
    load(0, 1'b1, 0, -3); load(1, 1'b1, 0, -1); load(2, 1'b0, 0, 2); load(3, 1'b0, 0, 5);
    run_scan(4, 10, 0, 1'b0);
    chk("t2_idx_i", 96'(idx_i), 96'(0));
    chk("t2_idx_j", 96'(idx_j), 96'(2));
    chk("t2_gap",   96'(gap),   96'(1));
    chk("t2_conv",  96'(converged), 96'(0));

    // Ties, back-to-back after the previous finish
    for (int k = 0; k < 3; k++) load(k, 1'b1, 0, -7);
    run_scan(3, 10, 0, 1'b0);
    chk("t3_vj",   96'(valid_j),   96'(0));
    chk("t3_conv", 96'(converged), 96'(1));

    // Back-to-back again, gap within eps
    load(0, 1'b1, 0, -4); load(1, 1'b0, 0, 3);
    run_scan(2, 10, 1, 1'b0);
    chk("t6_gap",  96'(gap),       96'(1));
    chk("t6_conv", 96'(converged), 96'(1));

    // n=0 with start repeated while busy
    repeat (2) @(negedge clk);
    run_scan(0, 10, 0, 1'b1);

    // Extremes: saturated negation and full-range gap
    load(0, 1'b0, 0,  64'sh8000_0000_0000_0000);
    load(1, 1'b1, 0,  64'sh8000_0000_0000_0000);
    load(2, 1'b1, 10, 5);
    load(3, 1'b0, 10, -100);
    repeat (2) @(negedge clk);
    run_scan(4, 10, 0, 1'b0);
    chk("t5_gap",  96'(gap),       96'(65'h0_ffff_ffff_ffff_ffff));
    chk("t5_conv", 96'(converged), 96'(0));

    // Random scans
    for (int s = 0; s < 8; s++) begin
      int     n;
      longint c;
      n = $urandom_range(1, 12);
      c = longint'($urandom_range(1, 8));
      for (int k = 0; k < n; k++) begin
        longint a, g;
        case ($urandom_range(0, 2))
          0:       a = 0;
          1:       a = c;
          default: a = longint'($urandom_range(0, 8));
        endcase
        case ($urandom_range(0, 9))
          0:       g = 64'sh8000_0000_0000_0000;
          1:       g = 64'sh7fff_ffff_ffff_ffff;
          default: g = longint'($urandom_range(0, 200)) - 100;
        endcase
        load(k, 1'($urandom_range(0, 1)), a, g);
      end
      run_scan(n, c, longint'($urandom_range(0, 20)), 1'b0);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    repeat (5) @(negedge clk);
    chk("queue_empty", 96'(exp_q.size()), 96'(0));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
